iic_write_sequencer: RTL and testbench



---
 rtl/iic_write_sequencer.sv | 147 ++++++++++++++
 tb/tb_iic_write_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_write_sequencer.sv
`default_nettype none
// ============================================================================
// iic_write_sequencer - FIFO-buffered write-command issuer for the I2C write
// controller, with an inter-transaction gap and a done_signal watchdog.
// Rev 1.0
// ============================================================================
module iic_write_sequencer #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_slave_addr,
  input  logic [6:0]               cmd_pointer,
  input  logic [7:0]               cmd_data,
  input  logic                     clr_err,
  output logic                     start_signal,
  output logic [6:0]               slave_addr,
  output logic [6:0]               slave_addr_pointer,
  output logic [7:0]               data,
  input  logic                     done_signal,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     txn_done,
  output logic                     timeout_err
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_GW = $clog2(GAP_CYCLES + 1);
  localparam int c_WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_AW:0]   c_FULL       = DEPTH[c_AW:0];
  localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(GAP_CYCLES - 1);
  localparam logic [c_WW-1:0] c_WDOG_LAST  = c_WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [21:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     w_count_next;
  logic [c_GW-1:0]   r_gap;
  logic [c_WW-1:0]   r_wdog;
  logic              w_push;
  logic              w_pop;
  logic              w_wdog_hit;

  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == S_IDLE) && (fifo_count != '0);
  assign w_wdog_hit = (r_wdog == c_WDOG_LAST);

  always_comb begin
    w_count_next = fifo_count;
    if (w_push && !w_pop) begin
      w_count_next = fifo_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_slave_addr, cmd_pointer, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      fifo_count <= w_count_next;
      cmd_ready  <= (w_count_next != c_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // done_signal beats the watchdog limit when both land in the same cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (fifo_count != '0) w_state_next = S_ISSUE;
      S_ISSUE:     w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done_signal)     w_state_next = S_GAP;
        else if (w_wdog_hit) w_state_next = S_ERROR;
      end
      S_GAP:       if (r_gap == c_GAP_LAST) w_state_next = S_IDLE;
      S_ERROR:     if (clr_err) w_state_next = S_GAP;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_signal       <= 1'b0;
      slave_addr         <= '0;
      slave_addr_pointer <= '0;
      data               <= '0;
      busy               <= 1'b0;
      txn_done           <= 1'b0;
      timeout_err        <= 1'b0;
      r_gap              <= '0;
      r_wdog             <= '0;
    end else begin
      start_signal <= w_pop;
      txn_done     <= (r_state == S_WAIT_DONE) && done_signal;
      busy         <= (w_state_next != S_IDLE);
      if (w_pop) begin
        {slave_addr, slave_addr_pointer, data} <= r_mem[r_rd_ptr];
      end
      // Watchdog is zero during ISSUE so it equals cycles elapsed since launch
      if (w_pop) begin
        r_wdog <= '0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT_DONE) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;
      if (r_state == S_WAIT_DONE && !done_signal && w_wdog_hit) begin
        timeout_err <= 1'b1;
      end else if (r_state == S_ERROR && clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iic_write_sequencer.sv
`default_nettype none
// Directed vector-table bench for iic_write_sequencer plus hand-written
// full-FIFO, timeout, watchdog-boundary and mid-transaction reset sequences.
module tb_iic_write_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int TO    = 4096;
  localparam logic [21:0] Z  = 22'h0;
  localparam logic [21:0] CA = {7'h50, 7'h12, 8'hA5};
  localparam logic [21:0] C1 = {7'h21, 7'h31, 8'h01};
  localparam logic [21:0] C2 = {7'h22, 7'h32, 8'h02};
  localparam logic [21:0] C3 = {7'h23, 7'h33, 8'h03};
  localparam logic [30:0] RST_VEC = {5'b00001, 4'd0, 22'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_slave_addr = '0;
  logic [6:0]  cmd_pointer = '0;
  logic [7:0]  cmd_data = '0;
  logic        clr_err = 1'b0;
  logic        start_signal;
  logic [6:0]  slave_addr;
  logic [6:0]  slave_addr_pointer;
  logic [7:0]  data;
  logic        done_signal = 1'b0;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        txn_done;
  logic        timeout_err;

  iic_write_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slave_addr(cmd_slave_addr), .cmd_pointer(cmd_pointer), .cmd_data(cmd_data),
    .clr_err(clr_err), .start_signal(start_signal), .slave_addr(slave_addr),
    .slave_addr_pointer(slave_addr_pointer), .data(data), .done_signal(done_signal),
    .busy(busy), .fifo_count(fifo_count), .txn_done(txn_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_txn = 0;
  logic [21:0] starts[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (start_signal) begin
        n_start++;
        starts.push_back({slave_addr, slave_addr_pointer, data});
      end
      if (txn_done) n_txn++;
    end
  end

  typedef struct {
    int          n;
    logic        v;
    logic [21:0] cmd;
    logic        dn;
    logic        clr;
    logic [30:0] exp;
  } vec_t;
  vec_t tbl[$];

  int full_cnt [10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};

  task automatic add(input int n, input logic v, input logic [21:0] cmd, input logic dn,
                     input logic clr, input logic st, input logic bz, input logic tx,
                     input logic [3:0] cnt, input logic [21:0] outs);
    vec_t r;
    r.n = n; r.v = v; r.cmd = cmd; r.dn = dn; r.clr = clr;
    r.exp = {st, bz, tx, 1'b0, 1'b1, cnt, outs};
    tbl.push_back(r);
  endtask

  function automatic logic [30:0] snap();
    return {start_signal, busy, txn_done, timeout_err, cmd_ready, fifo_count,
            slave_addr, slave_addr_pointer, data};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [21:0] cmd);
    cmd_valid = v;
    {cmd_slave_addr, cmd_pointer, cmd_data} = cmd;
  endtask

  task automatic wait_start(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (start_signal) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_start: no start_signal within %0d cycles", budget);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e;
    int ns;
    int nt;
    bit got;
    logic [21:0] w;

    // Single, queued and stray-done behaviour, cycle by cycle
    add(1,   1, CA, 0, 0, 0, 0, 0, 1, Z);
    add(1,   0, Z,  0, 0, 1, 1, 0, 0, CA);
    add(199, 0, Z,  0, 0, 0, 1, 0, 0, CA);
    add(1,   0, Z,  1, 0, 0, 1, 1, 0, CA);
    add(1,   1, C1, 0, 0, 0, 1, 0, 1, CA);
    add(1,   1, C2, 0, 0, 0, 1, 0, 2, CA);
    add(1,   1, C3, 0, 0, 0, 1, 0, 3, CA);
    add(12,  0, Z,  0, 0, 0, 1, 0, 3, CA);
    add(1,   0, Z,  0, 0, 0, 0, 0, 3, CA);
    add(1,   0, Z,  0, 0, 1, 1, 0, 2, C1);
    add(1,   0, Z,  1, 0, 0, 1, 0, 2, C1);
    add(2,   0, Z,  0, 0, 0, 1, 0, 2, C1);
    add(1,   0, Z,  1, 0, 0, 1, 1, 2, C1);
    add(15,  0, Z,  0, 0, 0, 1, 0, 2, C1);
    add(1,   0, Z,  0, 0, 0, 0, 0, 2, C1);
    add(1,   0, Z,  0, 0, 1, 1, 0, 1, C2);
    add(1,   0, Z,  0, 0, 0, 1, 0, 1, C2);
    add(1,   0, Z,  1, 0, 0, 1, 1, 1, C2);
    add(15,  0, Z,  0, 0, 0, 1, 0, 1, C2);
    add(1,   0, Z,  0, 0, 0, 0, 0, 1, C2);
    add(1,   0, Z,  0, 0, 1, 1, 0, 0, C3);
    add(1,   0, Z,  0, 0, 0, 1, 0, 0, C3);
    add(1,   0, Z,  1, 1, 0, 1, 1, 0, C3);
    add(15,  0, Z,  0, 0, 0, 1, 0, 0, C3);
    add(3,   0, Z,  0, 0, 0, 0, 0, 0, C3);

    rst = 1'b1;
    repeat (3) tick();
    check("reset_values", snap(), RST_VEC);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].cmd);
      done_signal = tbl[k].dn;
      clr_err     = tbl[k].clr;
      for (int j = 0; j < tbl[k].n; j++) begin
        tick();
        check($sformatf("vec%0d.%0d", k, j), snap(), tbl[k].exp);
      end
    end
    drive(1'b0, Z);
    done_signal = 1'b0;
    clr_err = 1'b0;

    // Full FIFO: the first command issues, then 9 more offered, one dropped
    starts.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, {7'h40, 7'h41, 8'(8'h80 + i)});
      tick();
      check($sformatf("full_cnt%0d", i), fifo_count, full_cnt[i]);
      check($sformatf("full_rdy%0d", i), cmd_ready, (full_cnt[i] != DEPTH));
    end
    drive(1'b0, Z);
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (k > 0) begin
        wait_start(GAP + 10);
        tick();
      end
      tick();
      done_signal = 1'b1;
      tick();
      done_signal = 1'b0;
    end
    repeat (GAP + 5) tick();
    check("full_n_starts", starts.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < starts.size(); i++) begin
      w = starts[i];
      check($sformatf("full_order%0d", i), w[7:0], 8'(8'h80 + i));
    end
    check("full_drained", fifo_count, 0);

    // Timeout, sticky error, clr_err release
    starts.delete();
    nt = n_txn;
    drive(1'b1, {7'h11, 7'h22, 8'hC1});
    tick();
    drive(1'b1, {7'h11, 7'h22, 8'hC2});
    tick();
    drive(1'b0, Z);
    check("to_start", start_signal, 1);
    e = cyc;
    got = 1'b0;
    for (int i = 0; i < TO + 20; i++) begin
      tick();
      if (timeout_err) begin
        got = 1'b1;
        break;
      end
    end
    check("to_seen", got, 1);
    check("to_latency", cyc - e, TO);
    check("to_busy", busy, 1);
    repeat (5) tick();
    check("to_sticky", {timeout_err, busy}, 2'b11);
    check("to_no_next_start", starts.size(), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_cleared", timeout_err, 0);
    e = cyc;
    wait_start(GAP + 10);
    check("to_restart_gap", cyc - e, GAP + 1);
    check("to_next_data", data, 8'hC2);
    tick();
    done_signal = 1'b1;
    tick();
    done_signal = 1'b0;
    repeat (2) tick();
    check("to_txn_count", n_txn - nt, 1);

    // done_signal in the exact watchdog-limit cycle
    repeat (GAP + 5) tick();
    drive(1'b1, {7'h33, 7'h44, 8'hB1});
    tick();
    drive(1'b0, Z);
    tick();
    check("bnd_start", start_signal, 1);
    e = cyc;
    while (cyc < e + TO - 1) tick();
    done_signal = 1'b1;
    tick();
    done_signal = 1'b0;
    check("bnd_txn_err", {txn_done, timeout_err}, 2'b10);
    tick();
    check("bnd_after", {timeout_err, busy}, 2'b01);

    // Reset mid-WAIT_DONE with 4 queued commands
    repeat (GAP + 5) tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {7'h55, 7'h66, 8'(8'hD0 + i)});
      tick();
    end
    drive(1'b0, Z);
    repeat (3) tick();
    check("rst_pre", {busy, fifo_count}, {1'b1, 4'd4});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", snap(), RST_VEC);
    ns = n_start;
    nt = n_txn;
    done_signal = 1'b1;
    tick();
    done_signal = 1'b0;
    repeat (40) tick();
    check("rst_no_start", n_start - ns, 0);
    check("rst_no_txn", n_txn - nt, 0);
    check("rst_idle", {busy, fifo_count, cmd_ready}, {1'b0, 4'd0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
